snake_seg_streamer: RTL

//  Consumes the processor's packed snake_data bus (NUM_SEGS words) and streams the occupied snake

---
 rtl/snake_seg_if.sv | 21 ++
 rtl/snake_seg_streamer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/snake_seg_if.sv
// Valid/ready segment stream from snake_seg_streamer (master) to the tile renderer (slave).
interface snake_seg_if #(
  parameter int COORD_W = 8
);
  logic               seg_valid;
  logic               seg_ready;
  logic [COORD_W-1:0] seg_x;
  logic [COORD_W-1:0] seg_y;
  logic               seg_is_head;
  logic               seg_last;

  modport master (
    output seg_valid, seg_x, seg_y, seg_is_head, seg_last,
    input  seg_ready
  );

  modport slave (
    input  seg_valid, seg_x, seg_y, seg_is_head, seg_last,
    output seg_ready
  );
endinterface

// File: rtl/snake_seg_streamer.sv
// Snapshots the packed snake_data bus on frame_start and streams occupied segments, one per beat.
// Optional head/body collision detection is built when SNAKE_COLLISION_DETECT_EN is defined.
module snake_seg_streamer #(
  parameter int NUM_SEGS = 12,
  parameter int WORD_W   = 32,
  parameter int COORD_W  = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SEGS*WORD_W-1:0] snake_data,
  input  logic                       frame_start,
  snake_seg_if.master                seg,
  output logic [3:0]                 seg_count,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       collision
);

  localparam int IDX_W    = $clog2(NUM_SEGS);
  localparam int UNUSED_W = WORD_W - 1 - 2 * COORD_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  snap_x_q [NUM_SEGS];
  logic [COORD_W-1:0]  snap_x_d [NUM_SEGS];
  logic [COORD_W-1:0]  snap_y_q [NUM_SEGS];
  logic [COORD_W-1:0]  snap_y_d [NUM_SEGS];
  logic [NUM_SEGS-1:0] pending_q, pending_d;
  logic [3:0]          count_q, count_d;
  logic                valid_q, valid_d;
  logic [COORD_W-1:0]  x_q, x_d;
  logic [COORD_W-1:0]  y_q, y_d;
  logic                head_q, head_d;
  logic                last_q, last_d;

  logic [COORD_W-1:0]  in_x [NUM_SEGS];
  logic [COORD_W-1:0]  in_y [NUM_SEGS];
  logic [NUM_SEGS-1:0] in_mask;
  logic [IDX_W-1:0]    pick_idx;
  logic                load_en;
  logic                take;

  // Bits [30:16] of every word carry nothing this block uses.
  logic [NUM_SEGS-1:0] unused_word_bits;

  always_comb begin
    for (int i = 0; i < NUM_SEGS; i++) begin
      in_mask[i]          = snake_data[i*WORD_W + WORD_W - 1];
      in_x[i]             = snake_data[i*WORD_W + COORD_W +: COORD_W];
      in_y[i]             = snake_data[i*WORD_W +: COORD_W];
      unused_word_bits[i] = ^snake_data[i*WORD_W + 2*COORD_W +: UNUSED_W];
    end
  end

  function automatic logic [3:0] popcount(input logic [NUM_SEGS-1:0] m);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_SEGS; i++) cnt = cnt + {3'b000, m[i]};
    return cnt;
  endfunction

  // Lowest-index pending word is the next beat, so invalid words never cost a cycle.
  always_comb begin
    pick_idx = '0;
    for (int i = NUM_SEGS - 1; i >= 0; i--) begin
      if (pending_q[i]) pick_idx = IDX_W'(i);
    end
  end

  // State register (with the datapath registers it sequences).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      // NOTE: the snapshot is a handful of flops, not a RAM, and must read 0 after reset, so it is reset too.
      snap_x_q  <= '{default: '0};
      snap_y_q  <= '{default: '0};
      pending_q <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      head_q    <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values computed by the comb block.
      state_q   <= state_d;
      snap_x_q  <= snap_x_d;
      snap_y_q  <= snap_y_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      x_q       <= x_d;
      y_q       <= y_d;
      head_q    <= head_d;
      last_q    <= last_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: every target gets a hold default first so no path through the case infers a latch.
    state_d   = state_q;
    snap_x_d  = snap_x_q;
    snap_y_d  = snap_y_q;
    pending_d = pending_q;
    count_d   = count_q;
    valid_d   = valid_q;
    x_d       = x_q;
    y_d       = y_q;
    head_d    = head_q;
    last_d    = last_q;
    take      = 1'b0;
    load_en   = !valid_q || seg.seg_ready;

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          take      = 1'b1;
          snap_x_d  = in_x;
          snap_y_d  = in_y;
          pending_d = in_mask;
          count_d   = popcount(in_mask);
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (load_en) begin
          if (|pending_q) begin
            valid_d             = 1'b1;
            x_d                 = snap_x_q[pick_idx];
            y_d                 = snap_y_q[pick_idx];
            head_d              = (pick_idx == '0);
            pending_d[pick_idx] = 1'b0;
            // Entries are drained low to high, so nothing left pending means highest set bit.
            last_d              = ~|pending_d;
          end else begin
            // Either the last beat just transferred or the snapshot was empty.
            valid_d = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_DONE);
  end

  assign seg.seg_valid   = valid_q;
  assign seg.seg_x       = x_q;
  assign seg.seg_y       = y_q;
  assign seg.seg_is_head = head_q;
  assign seg.seg_last    = last_q;
  assign seg_count       = count_q;

`ifdef SNAKE_COLLISION_DETECT_EN
  logic [NUM_SEGS-1:0] snap_vld_q;
  logic                eval_q;
  logic                collision_q;
  logic                hit;

  always_comb begin
    hit = 1'b0;
    for (int i = 1; i < NUM_SEGS; i++) begin
      if (snap_vld_q[i] && snap_x_q[i] == snap_x_q[0] && snap_y_q[i] == snap_y_q[0]) hit = 1'b1;
    end
    hit = hit & snap_vld_q[0];
  end

  // Compared against the frozen snapshot one edge after capture, then held for the frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap_vld_q  <= '0;
      eval_q      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      eval_q <= take;
      if (take) begin
        snap_vld_q  <= in_mask;
        collision_q <= 1'b0;
      end else if (eval_q) begin
        collision_q <= hit;
      end
    end
  end

  assign collision = collision_q;
`else
  assign collision = 1'b0;
`endif

endmodule
